// File: rtl/clock_monitor_pkg.sv
// Shared types and default sizes for the pll_clk-based
// external clock frequency monitor.
package clock_monitor_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 8;
    localparam int TO_W_DEF  = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

endpackage

// File: rtl/clock_monitor_if.sv
// Request/result bundle between a controller and the monitor.
// master drives the request, slave returns the result.
interface clock_monitor_if
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] lo_lim;
    logic [CNT_W-1:0] hi_lim;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             too_low;
    logic             too_high;
    logic             ext_dead;

    modport master (
        output start, win_len, lo_lim, hi_lim,
        input  busy, done, count, too_low, too_high, ext_dead
    );

    modport slave (
        input  start, win_len, lo_lim, hi_lim,
        output busy, done, count, too_low, too_high, ext_dead
    );
endinterface

// File: rtl/sync_edge_det.sv
// Brings an asynchronous signal into clk with two flops and
// flags its rising edge using a third flop.
module sync_edge_det (
    input  logic clk,
    input  logic resetb_async,
    input  logic d_async,
    output logic rise
);
    logic s1, s2, s3;

    // synchronizer pair followed by the edge-history flop
    always_ff @(posedge clk or negedge resetb_async) begin
        if (!resetb_async) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d_async;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/clock_monitor.sv
// Counts pll_clk cycles across a window of ext_clk rising edges
// and flags the result against limits or a dead external clock.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic            pll_clk,
    input  logic            resetb_async,
    input  logic            ext_clk,
    clock_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    logic             ext_rise;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] edge_q, edge_d, edge_inc;
    logic [TO_W-1:0]  to_q, to_d, to_inc;
    logic             load, dead;
    logic [CNT_W-1:0] res_cnt;
    logic             res_low, res_high;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] count_q;
    logic             low_q, high_q, dead_q;

    sync_edge_det u_sync (
        .clk          (pll_clk),
        .resetb_async (resetb_async),
        .d_async      (ext_clk),
        .rise         (ext_rise)
    );

    // next state, counters, and the result captured on entry to DONE
    always_comb begin
        state_nxt = state;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        win_d     = win_q;
        edge_d    = edge_q;
        to_d      = to_q;
        load      = 1'b0;
        dead      = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        edge_inc  = edge_q + 1'b1;
        to_inc    = to_q + 1'b1;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ARM;
                    win_d     = (bus.win_len == '0) ? WIN_ONE
                                                    : bus.win_len;
                    lo_d      = bus.lo_lim;
                    hi_d      = bus.hi_lim;
                    cnt_d     = '0;
                    edge_d    = '0;
                    to_d      = '0;
                end
            end
            S_ARM: begin
                if (ext_rise) begin
                    state_nxt = S_MEASURE;
                    cnt_d     = '0;
                    edge_d    = '0;
                    to_d      = '0;
                end else if (to_q == TO_MAX) begin
                    state_nxt = S_DONE;
                    load      = 1'b1;
                    dead      = 1'b1;
                end else begin
                    to_d = to_inc;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_inc;
                if (ext_rise) begin
                    to_d   = '0;
                    edge_d = edge_inc;
                    if (edge_inc == win_q) begin
                        state_nxt = S_DONE;
                        load      = 1'b1;
                    end
                end else if (to_q == TO_MAX) begin
                    state_nxt = S_DONE;
                    load      = 1'b1;
                    dead      = 1'b1;
                end else begin
                    to_d = to_inc;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
        endcase
        res_cnt  = dead ? '0 : cnt_inc;
        res_low  = dead | (res_cnt < lo_q);
        res_high = ~dead & (res_cnt > hi_q);
    end

    // state, working counters and registered result outputs
    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            win_q   <= '0;
            edge_q  <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            low_q   <= 1'b0;
            high_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            win_q  <= win_d;
            edge_q <= edge_d;
            to_q   <= to_d;
            busy_q <= (state_nxt == S_ARM) ||
                      (state_nxt == S_MEASURE);
            done_q <= load;
            if (load) begin
                count_q <= res_cnt;
                low_q   <= res_low;
                high_q  <= res_high;
                dead_q  <= dead;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.too_low  = low_q;
    assign bus.too_high = high_q;
    assign bus.ext_dead = dead_q;
endmodule

// File: tb/tb_clock_monitor.sv
// Directed checks of clock_monitor: window counts, limit flags,
// dead-clock timeout, saturation, busy-start and mid-run reset.
module tb_clock_monitor;
    logic pll_clk;
    logic resetb_async;
    logic ext_clk;
    int   ext_half;
    int   checks;
    int   errors;
    int   cyc;
    int   n;

    clock_monitor_if #(.CNT_W(16), .WIN_W(8)) bus0 ();
    clock_monitor_if #(.CNT_W(4),  .WIN_W(8)) bus1 ();

    clock_monitor #(.CNT_W(16), .WIN_W(8), .TO_W(6)) u0 (
        .pll_clk      (pll_clk),
        .resetb_async (resetb_async),
        .ext_clk      (ext_clk),
        .bus          (bus0.slave)
    );

    clock_monitor #(.CNT_W(4), .WIN_W(8), .TO_W(8)) u1 (
        .pll_clk      (pll_clk),
        .resetb_async (resetb_async),
        .ext_clk      (ext_clk),
        .bus          (bus1.slave)
    );

    // 100 MHz pll_clk
    initial begin
        pll_clk = 1'b0;
        forever #5 pll_clk = ~pll_clk;
    end

    // ext_clk with programmable half period, 0 holds it low
    initial begin
        ext_clk = 1'b0;
        #2;
        forever begin
            if (ext_half == 0) begin
                ext_clk = 1'b0;
                #10;
            end else begin
                ext_clk = 1'b1;
                #(ext_half);
                ext_clk = 1'b0;
                #(ext_half);
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag,
                             input logic [31:0] obs,
                             input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    task automatic start0(input logic [7:0] w,
                          input logic [15:0] lo,
                          input logic [15:0] hi);
        bus0.start   = 1'b1;
        bus0.win_len = w;
        bus0.lo_lim  = lo;
        bus0.hi_lim  = hi;
        @(negedge pll_clk);
        bus0.start   = 1'b0;
    endtask

    task automatic wait0(input int budget, output int c);
        c = 1;
        while (bus0.done !== 1'b1 && c < budget) begin
            @(negedge pll_clk);
            c++;
        end
    endtask

    task automatic run0(input string tag,
                        input logic [7:0] w,
                        input logic [15:0] lo,
                        input logic [15:0] hi,
                        input int exp_cnt,
                        input logic exp_low,
                        input logic exp_high);
        int c;
        start0(w, lo, hi);
        wait0(300, c);
        check({tag, "_done"}, bus0.done, 1);
        check_rng({tag, "_count"}, bus0.count,
                  exp_cnt - 1, exp_cnt + 1);
        check({tag, "_low"}, bus0.too_low, exp_low);
        check({tag, "_high"}, bus0.too_high, exp_high);
        check({tag, "_dead"}, bus0.ext_dead, 0);
        @(negedge pll_clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        ext_half      = 50;
        resetb_async  = 1'b1;
        bus0.start    = 1'b0;
        bus0.win_len  = '0;
        bus0.lo_lim   = '0;
        bus0.hi_lim   = '0;
        bus1.start    = 1'b0;
        bus1.win_len  = '0;
        bus1.lo_lim   = '0;
        bus1.hi_lim   = '0;

        #3 resetb_async = 1'b0;
        #2;
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_count", bus0.count, 0);
        check("rst_low", bus0.too_low, 0);
        check("rst_high", bus0.too_high, 0);
        check("rst_dead", bus0.ext_dead, 0);
        repeat (3) @(negedge pll_clk);
        resetb_async = 1'b1;
        repeat (20) @(negedge pll_clk);

        // nominal 10:1 ratio over four edges
        start0(8'd4, 16'd35, 16'd45);
        check("nom_busy", bus0.busy, 1);
        wait0(300, cyc);
        check("nom_done", bus0.done, 1);
        check("nom_busy_drop", bus0.busy, 0);
        check_rng("nom_count", bus0.count, 39, 41);
        check("nom_low", bus0.too_low, 0);
        check("nom_high", bus0.too_high, 0);
        check("nom_dead", bus0.ext_dead, 0);
        @(negedge pll_clk);
        check("nom_pulse", bus0.done, 0);
        repeat (5) @(negedge pll_clk);
        check_rng("nom_hold", bus0.count, 39, 41);

        // win_len 0 behaves as a single-edge window
        run0("win0", 8'd0, 16'd0, 16'd100, 10, 1'b0, 1'b0);
        // limit flags on both sides and crossed limits
        run0("low", 8'd4, 16'd50, 16'd60, 40, 1'b1, 1'b0);
        run0("high", 8'd4, 16'd10, 16'd20, 40, 1'b0, 1'b1);
        run0("cross", 8'd4, 16'd50, 16'd30, 40, 1'b1, 1'b1);
        run0("equal", 8'd4, 16'd40, 16'd40, 40, 1'b0, 1'b0);

        // second start while busy must not disturb the run
        start0(8'd4, 16'd35, 16'd45);
        repeat (8) @(negedge pll_clk);
        start0(8'd1, 16'd0, 16'd0);
        wait0(300, cyc);
        check("busy_done", bus0.done, 1);
        check_rng("busy_count", bus0.count, 39, 41);
        check("busy_high", bus0.too_high, 0);
        n = 0;
        repeat (60) begin
            @(negedge pll_clk);
            if (bus0.done === 1'b1) n++;
        end
        check("busy_one_done", n, 0);

        // dead clock: timeout after 64 cycles
        ext_half = 0;
        repeat (30) @(negedge pll_clk);
        start0(8'd4, 16'd0, 16'd0);
        wait0(200, cyc);
        check("dead_done", bus0.done, 1);
        check_rng("dead_latency", cyc, 61, 67);
        check("dead_flag", bus0.ext_dead, 1);
        check("dead_count", bus0.count, 0);
        check("dead_low", bus0.too_low, 1);
        check("dead_high", bus0.too_high, 0);
        @(negedge pll_clk);

        // 4-bit counter saturates over a 40-cycle period
        ext_half = 200;
        repeat (60) @(negedge pll_clk);
        bus1.start   = 1'b1;
        bus1.win_len = 8'd1;
        bus1.lo_lim  = 4'd0;
        bus1.hi_lim  = 4'd10;
        @(negedge pll_clk);
        bus1.start = 1'b0;
        cyc = 1;
        while (bus1.done !== 1'b1 && cyc < 300) begin
            @(negedge pll_clk);
            cyc++;
        end
        check("sat_done", bus1.done, 1);
        check("sat_count", bus1.count, 15);
        check("sat_high", bus1.too_high, 1);
        check("sat_low", bus1.too_low, 0);

        // reset in the middle of a measurement
        ext_half = 50;
        repeat (30) @(negedge pll_clk);
        start0(8'd4, 16'd35, 16'd45);
        repeat (20) @(negedge pll_clk);
        resetb_async = 1'b0;
        #1;
        check("mid_busy", bus0.busy, 0);
        check("mid_done", bus0.done, 0);
        check("mid_dead", bus0.ext_dead, 0);
        check("mid_low", bus0.too_low, 0);
        repeat (3) @(negedge pll_clk);
        resetb_async = 1'b1;
        n = 0;
        repeat (60) begin
            @(negedge pll_clk);
            if (bus0.done === 1'b1) n++;
        end
        check("mid_no_done", n, 0);
        check("mid_idle", bus0.busy, 0);
        run0("post", 8'd4, 16'd35, 16'd45, 40, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the pll_clk cycle counter and the limits.
REQ-002 SHALL have parameter WIN_W, default 8, width of the window-length input.
REQ-003 SHALL have parameter TO_W, default 12; the dead-clock timeout is 2^TO_W pll_clk cycles.
REQ-004 pll_clk  input  1  sole clock; every flop is in this domain.
REQ-005 resetb_async  input  1  asynchronous, active-low reset.
REQ-006 ext_clk  input  1  external pad clock, asynchronous to pll_clk, being measured.
REQ-007 start  input  1  synchronous request to begin one measurement.
REQ-008 win_len  input  WIN_W  window length in ext_clk rising edges; sampled on accepted start.
REQ-009 lo_lim  input  CNT_W  minimum acceptable count; sampled on accepted start.
REQ-010 hi_lim  input  CNT_W  maximum acceptable count; sampled on accepted start.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when a result is valid.
REQ-013 count  output  CNT_W  pll_clk cycles counted over the window; held until the next done.
REQ-014 too_low, too_high, ext_dead  output  1 each  result flags, held with count.

Function
REQ-015 ext_clk SHALL pass through a 2-flop synchronizer plus a third flop; an ext rising edge (ext_rise) is sync2=1 and sync3=0.
REQ-016 The FSM SHALL have states IDLE, ARM, MEASURE, DONE.
REQ-017 IDLE: start=1 accepts; SHALL latch win_len, lo_lim, hi_lim, clear the counter and timeout timer, and go to ARM.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 win_len=0 SHALL be treated as 1.
REQ-020 ARM: on ext_rise go to MEASURE with counter=0 and edge counter=0.
REQ-021 MEASURE: the counter SHALL increment every cycle and saturate at all-ones; each ext_rise increments the edge counter.
REQ-022 MEASURE: on the ext_rise that makes the edge count equal the latched window, go to DONE; that cycle's increment is included.
REQ-023 In ARM and MEASURE the timeout timer SHALL restart on every ext_rise; reaching 2^TO_W-1 SHALL go to DONE with ext_dead=1 and count=0.
REQ-024 DONE: for one cycle assert done and update count and flags, then go to IDLE; busy SHALL drop in the same cycle done asserts.
REQ-025 too_low SHALL be (count < lo_lim); too_high SHALL be (count > hi_lim), unsigned; when ext_dead=1, too_low=1 and too_high=0.
REQ-026 If lo_lim > hi_lim, both flags SHALL be evaluated independently without any error indication.
REQ-027 Latency: done SHALL assert exactly 1 cycle after the pll_clk edge on which the final ext_rise is detected.

Reset
REQ-028 resetb_async low SHALL asynchronously force: state IDLE, busy=0, done=0, count=0, too_low=0, too_high=0, ext_dead=0, synchronizer flops=0, all counters=0.
REQ-029 Reset asserted mid-measurement SHALL abort it without producing a done pulse.
REQ-030 Release of reset SHALL take effect on the next pll_clk edge; the first start is accepted no earlier than the first edge after release.

Structure
REQ-031 State encodings and the default parameter values SHALL live in a shared package, clock_monitor_pkg.
REQ-032 The 3-flop synchronizer/edge detector SHALL be a sub-module, sync_edge_det, reusable by other blocks.

Verification
REQ-033 pll_clk 100 MHz, ext_clk 10 MHz, win_len=4, lo_lim=35, hi_lim=45 -> done once, count 40 +/-1, too_low=0, too_high=0, ext_dead=0.
REQ-034 ext_clk held at 0, TO_W=6, start -> done 64 +/-3 cycles after start, ext_dead=1, count=0, too_low=1.
REQ-035 win_len=0, ext period 10 pll cycles -> count 10 +/-1 (single-edge window).
REQ-036 CNT_W=4, ext period 40 pll cycles, win_len=1 -> count saturates at 15, too_high=1 with hi_lim=10.
REQ-037 start pulsed again while busy -> ignored; exactly one done; latched limits unchanged.
REQ-038 resetb_async pulsed low during MEASURE -> no done; all outputs 0; a following start measures normally.
